ceu_a_feeder: RTL and testbench
===============================

Name: ceu_a_feeder

Overview:
Initiator-side controller for the CEU_a covariance-element unit.
- On `start`, reads the 11 operands CEU_a consumes from the shared covariance/noise memory.
- Presents the operands to CEU_a as registered, stable buses and waits for CEU_a `valid_out`. Valid outputs produced while the pipeline still holds stale data are discarded.
- Writes the accepted `a_out` back to memory and reports `done`/`error`.
- Sits between the matrix memory and one CEU_a instance in the Kalman predict path.

Parameters:
- DBL_WIDTH, 64, operand/result word width (IEEE-754 double)
- ADDR_W, 8, memory address width
- SETTLE_CYCLES, 40, CEU `valid_out` ignored for this many cycles after operands go stable
- TIMEOUT_CYCLES, 512, HOLD cycles before abort; must be > SETTLE_CYCLES
- RES_ADDR, 0, write-back address of the result (Theta_1_1)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; honoured only in IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- error  out  1  one-cycle pulse with `done` on timeout
- rd_en  out  1  memory read strobe
- rd_addr  out  ADDR_W  read address
- rd_data  in  DBL_WIDTH  read data, valid exactly 1 cycle after `rd_en`
- op_theta_4_1, op_theta_7_1, op_theta_4_4, op_theta_10_1, op_theta_7_4, op_theta_10_4, op_theta_7_7, op_theta_10_7, op_theta_10_10, op_q_1_1, op_r_1_1  out  DBL_WIDTH each  operand buses to CEU_a
- ops_valid  out  1  operand buses stable and meaningful
- ceu_result  in  DBL_WIDTH  CEU_a `a_out`
- ceu_valid  in  1  CEU_a `valid_out`
- wr_en  out  1  memory write strobe
- wr_addr  out  ADDR_W  write address (always RES_ADDR)
- wr_data  out  DBL_WIDTH  write data
- result_out  out  DBL_WIDTH  last accepted result, held until the next accept

Behaviour:
- Reset:
  - All outputs 0 (including all op_* buses and `result_out`); state IDLE; counters cleared.
  - Reset mid-operation aborts at once; no write, no `done`.
- Read order and address, index k=0..10:
  - 36 Theta_4_1, 72 Theta_7_1, 39 Theta_4_4, 108 Theta_10_1, 75 Theta_7_4
  - 111 Theta_10_4, 78 Theta_7_7, 114 Theta_10_7, 117 Theta_10_10
  - 144 Q_1_1, 145 R_1_1
  - Theta_i_j address = (i-1)*12 + (j-1).
- IDLE:
  - `start`=1 moves to FETCH next cycle.
  - `ops_valid` drops to 0; op_* buses keep their last values.
- FETCH:
  - `rd_en`=1 for 11 consecutive cycles, `rd_addr` per table.
  - A delayed index register steers `rd_data` into the matching op_* register one cycle later.
  - After the 11th read, one extra cycle (DRAIN) captures R_1_1, then the block enters HOLD.
  - Timing: `start` at cycle 0 gives `rd_en` on cycles 1–11 and `ops_valid`=1 from cycle 13.
- HOLD:
  - op_* buses frozen; `hold_cnt` increments each cycle from 0.
  - `ceu_valid` is ignored while `hold_cnt` < SETTLE_CYCLES.
  - First `ceu_valid`=1 with `hold_cnt` >= SETTLE_CYCLES: latch `ceu_result` into `result_out` and go to WB.
  - If `hold_cnt` reaches TIMEOUT_CYCLES-1 without acceptance, go to ABORT.
- WB (1 cycle): `wr_en`=1, `wr_addr`=RES_ADDR, `wr_data`=`result_out`, `done`=1; then IDLE.
- ABORT (1 cycle): `done`=1, `error`=1, no write, `result_out` unchanged; then IDLE.
- Acceptance and timeout in the same cycle: acceptance wins.
- `start` while `busy`=1 is ignored, not queued.
- `start` in the same cycle that `done` pulses is ignored, because the state is not yet IDLE.
- `rd_en` and `wr_en` are never high together.
- `hold_cnt` width is clog2(TIMEOUT_CYCLES)+1; it saturates and never wraps.

Optional Feature:
- Macro: CEU_FEED_PERF_EN.
- Defined:
  - Adds output `perf_latency [15:0]`, reset 0.
  - On each `done`, it loads the number of cycles from `start` acceptance to `done`; it saturates at 16'hFFFF.
  - Also adds output `perf_timeouts [7:0]`, which counts ABORT events and saturates at 255.
- Undefined: neither port exists and there are no counters; all other behaviour is identical.

Test Plan:
- Load memory so addr N holds 64'h4000_0000_0000_0000+N. Pulse `start`; model CEU `valid` 30 cycles after `ops_valid`.
  -> `rd_addr` sequence 36,72,39,108,75,111,78,114,117,144,145 on cycles 1–11.
  -> `op_theta_10_1`=64'h4000_0000_0000_006C; `ops_valid`=1 at cycle 13.
- CEU model holds `ceu_valid`=1 with stale 64'hDEAD... for HOLD cycles 0–39, then returns 64'h3FF8_0000_0000_0000 (1.5) at `hold_cnt`=45.
  -> stale value not accepted; `wr_en` at addr 0 with data 3FF8_0000_0000_0000; `done`=1, `error`=0.
- `ceu_valid` never asserted.
  -> `done`=`error`=1 exactly 512 cycles after HOLD entry; `wr_en` never 1; `busy` low the next cycle.
- Second `start` pulse at cycle 5 of a run.
  -> exactly one read sequence and one `done`.
- Assert `rst` on cycle 7 (mid-FETCH).
  -> next cycle all outputs 0 and state IDLE; a following `start` restarts from address 36.
- With CEU_FEED_PERF_EN, run the second scenario.
  -> `perf_latency` = 13+45+1 = 59; after the timeout scenario, `perf_timeouts`=1.

Source files
------------

// File: rtl/ceu_a_feeder.sv
// rtl/ceu_a_feeder.sv - operand fetch, settle/accept and write-back controller for one CEU_a
//
// Reads the 11 CEU_a operands from the shared covariance/noise memory and
// holds them on registered buses. It then accepts the first CEU valid that
// arrives once the settle window has passed and writes the result back.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start                     one-cycle request, honoured only when idle
//   busy, done, error         status; done/error are one-cycle pulses
//   rd_en, rd_addr, rd_data   memory read port (data one cycle after rd_en)
//   op_*                      operand buses to CEU_a, ops_valid when stable
//   ceu_result, ceu_valid     CEU_a a_out / valid_out
//   wr_en, wr_addr, wr_data   memory write port (result write-back)
//   result_out                last accepted result
//   perf_latency, perf_timeouts  only when CEU_FEED_PERF_EN is defined
//
// Optional feature macro: CEU_FEED_PERF_EN
module ceu_a_feeder #(
    parameter int DBL_WIDTH      = 64,
    parameter int ADDR_W         = 8,
    parameter int SETTLE_CYCLES  = 40,
    parameter int TIMEOUT_CYCLES = 512,
    parameter int RES_ADDR       = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic                 rd_en,
    output logic [ADDR_W-1:0]    rd_addr,
    input  logic [DBL_WIDTH-1:0] rd_data,
    output logic [DBL_WIDTH-1:0] op_theta_4_1,
    output logic [DBL_WIDTH-1:0] op_theta_7_1,
    output logic [DBL_WIDTH-1:0] op_theta_4_4,
    output logic [DBL_WIDTH-1:0] op_theta_10_1,
    output logic [DBL_WIDTH-1:0] op_theta_7_4,
    output logic [DBL_WIDTH-1:0] op_theta_10_4,
    output logic [DBL_WIDTH-1:0] op_theta_7_7,
    output logic [DBL_WIDTH-1:0] op_theta_10_7,
    output logic [DBL_WIDTH-1:0] op_theta_10_10,
    output logic [DBL_WIDTH-1:0] op_q_1_1,
    output logic [DBL_WIDTH-1:0] op_r_1_1,
    output logic                 ops_valid,
    input  logic [DBL_WIDTH-1:0] ceu_result,
    input  logic                 ceu_valid,
    output logic                 wr_en,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic [DBL_WIDTH-1:0] wr_data,
    output logic [DBL_WIDTH-1:0] result_out
`ifdef CEU_FEED_PERF_EN
    ,
    output logic [15:0]          perf_latency,
    output logic [7:0]           perf_timeouts
`endif
);

    localparam int HC_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [HC_W-1:0] SETTLE_HC    = HC_W'(SETTLE_CYCLES);
    localparam logic [HC_W-1:0] TIMEOUT_LAST = HC_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]      LAST_IDX     = 4'd10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN,
        S_HOLD,
        S_WB,
        S_ABORT
    } state_t;

    state_t          state;
    logic [3:0]      rd_idx;   // index of the read currently on rd_addr
    logic [3:0]      cap_idx;  // rd_idx delayed to line up with rd_data
    logic            cap_vld;
    logic [HC_W-1:0] hold_cnt;
    logic            accept;
    logic            expire;

    // Theta_i_j lives at (i-1)*12 + (j-1); Q_1_1 and R_1_1 follow at 144/145.
    function automatic logic [ADDR_W-1:0] op_addr(input logic [3:0] k);
        logic [ADDR_W-1:0] a;
        case (k)
            4'd0:    a = ADDR_W'(36);
            4'd1:    a = ADDR_W'(72);
            4'd2:    a = ADDR_W'(39);
            4'd3:    a = ADDR_W'(108);
            4'd4:    a = ADDR_W'(75);
            4'd5:    a = ADDR_W'(111);
            4'd6:    a = ADDR_W'(78);
            4'd7:    a = ADDR_W'(114);
            4'd8:    a = ADDR_W'(117);
            4'd9:    a = ADDR_W'(144);
            4'd10:   a = ADDR_W'(145);
            default: a = '0;
        endcase
        return a;
    endfunction

    // Acceptance is checked before the timeout so a valid on the last hold
    // cycle still counts.
    assign accept = (state == S_HOLD) && ceu_valid && (hold_cnt >= SETTLE_HC);
    assign expire = (state == S_HOLD) && !accept && (hold_cnt == TIMEOUT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            rd_idx         <= '0;
            cap_idx        <= '0;
            cap_vld        <= 1'b0;
            hold_cnt       <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            rd_en          <= 1'b0;
            rd_addr        <= '0;
            ops_valid      <= 1'b0;
            wr_en          <= 1'b0;
            wr_addr        <= '0;
            wr_data        <= '0;
            result_out     <= '0;
            op_theta_4_1   <= '0;
            op_theta_7_1   <= '0;
            op_theta_4_4   <= '0;
            op_theta_10_1  <= '0;
            op_theta_7_4   <= '0;
            op_theta_10_4  <= '0;
            op_theta_7_7   <= '0;
            op_theta_10_7  <= '0;
            op_theta_10_10 <= '0;
            op_q_1_1       <= '0;
            op_r_1_1       <= '0;
        end else begin
            done    <= 1'b0;
            error   <= 1'b0;
            wr_en   <= 1'b0;
            cap_vld <= rd_en;
            cap_idx <= rd_idx;

            if (cap_vld) begin
                case (cap_idx)
                    4'd0:    op_theta_4_1   <= rd_data;
                    4'd1:    op_theta_7_1   <= rd_data;
                    4'd2:    op_theta_4_4   <= rd_data;
                    4'd3:    op_theta_10_1  <= rd_data;
                    4'd4:    op_theta_7_4   <= rd_data;
                    4'd5:    op_theta_10_4  <= rd_data;
                    4'd6:    op_theta_7_7   <= rd_data;
                    4'd7:    op_theta_10_7  <= rd_data;
                    4'd8:    op_theta_10_10 <= rd_data;
                    4'd9:    op_q_1_1       <= rd_data;
                    4'd10:   op_r_1_1       <= rd_data;
                    default: ;
                endcase
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_FETCH;
                        busy    <= 1'b1;
                        rd_en   <= 1'b1;
                        rd_idx  <= '0;
                        rd_addr <= op_addr(4'd0);
                    end
                end
                S_FETCH: begin
                    if (rd_idx == LAST_IDX) begin
                        rd_en   <= 1'b0;
                        rd_addr <= '0;
                        state   <= S_DRAIN;
                    end else begin
                        rd_idx  <= rd_idx + 4'd1;
                        rd_addr <= op_addr(rd_idx + 4'd1);
                    end
                end
                S_DRAIN: begin
                    // R_1_1 lands in this cycle, so the buses are complete next cycle.
                    ops_valid <= 1'b1;
                    hold_cnt  <= '0;
                    state     <= S_HOLD;
                end
                S_HOLD: begin
                    if (accept) begin
                        result_out <= ceu_result;
                        wr_en      <= 1'b1;
                        wr_addr    <= ADDR_W'(RES_ADDR);
                        wr_data    <= ceu_result;
                        done       <= 1'b1;
                        state      <= S_WB;
                    end else if (expire) begin
                        done  <= 1'b1;
                        error <= 1'b1;
                        state <= S_ABORT;
                    end else if (hold_cnt != '1) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                S_WB, S_ABORT: begin
                    state     <= S_IDLE;
                    busy      <= 1'b0;
                    ops_valid <= 1'b0;
                    wr_addr   <= '0;
                    wr_data   <= '0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef CEU_FEED_PERF_EN
    logic [15:0] lat_cnt;

    // lat_cnt equals cycles elapsed since start was taken; the +1 accounts
    // for the done cycle that follows the decision cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_cnt       <= '0;
            perf_latency  <= '0;
            perf_timeouts <= '0;
        end else begin
            if (state == S_IDLE && start) begin
                lat_cnt <= 16'd1;
            end else if (busy && lat_cnt != 16'hFFFF) begin
                lat_cnt <= lat_cnt + 16'd1;
            end
            if (accept || expire) begin
                perf_latency <= (lat_cnt == 16'hFFFF) ? 16'hFFFF : lat_cnt + 16'd1;
            end
            if (expire && perf_timeouts != 8'hFF) begin
                perf_timeouts <= perf_timeouts + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ceu_a_feeder.sv
// tb/tb_ceu_a_feeder.sv - self-checking bench for ceu_a_feeder
module tb_ceu_a_feeder;

    localparam int DW     = 64;
    localparam int AW     = 8;
    localparam int SETTLE = 40;
    localparam int TMO    = 512;
    localparam logic [63:0] STALE = 64'hDEAD_BEEF_DEAD_BEEF;
    localparam logic [63:0] BASE  = 64'h4000_0000_0000_0000;
    localparam int NEVER = 100000;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy, done, error;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] op_theta_4_1, op_theta_7_1, op_theta_4_4, op_theta_10_1;
    logic [DW-1:0] op_theta_7_4, op_theta_10_4, op_theta_7_7, op_theta_10_7;
    logic [DW-1:0] op_theta_10_10, op_q_1_1, op_r_1_1;
    logic          ops_valid;
    logic [DW-1:0] ceu_result;
    logic          ceu_valid;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] result_out;

    int checks   = 0;
    int failures = 0;

    ceu_a_feeder dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .error(error),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .op_theta_4_1(op_theta_4_1), .op_theta_7_1(op_theta_7_1),
        .op_theta_4_4(op_theta_4_4), .op_theta_10_1(op_theta_10_1),
        .op_theta_7_4(op_theta_7_4), .op_theta_10_4(op_theta_10_4),
        .op_theta_7_7(op_theta_7_7), .op_theta_10_7(op_theta_10_7),
        .op_theta_10_10(op_theta_10_10), .op_q_1_1(op_q_1_1), .op_r_1_1(op_r_1_1),
        .ops_valid(ops_valid), .ceu_result(ceu_result), .ceu_valid(ceu_valid),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .result_out(result_out)
    );

    always #5 clk = ~clk;

    // Memory: address N holds BASE+N, returned one cycle after the read strobe.
    always @(posedge clk) begin
        rd_data <= rd_en ? (BASE + 64'(rd_addr)) : 64'h0BAD_0BAD_0BAD_0BAD;
    end

    logic [DW-1:0] ops [11];
    assign ops[0]  = op_theta_4_1;
    assign ops[1]  = op_theta_7_1;
    assign ops[2]  = op_theta_4_4;
    assign ops[3]  = op_theta_10_1;
    assign ops[4]  = op_theta_7_4;
    assign ops[5]  = op_theta_10_4;
    assign ops[6]  = op_theta_7_7;
    assign ops[7]  = op_theta_10_7;
    assign ops[8]  = op_theta_10_10;
    assign ops[9]  = op_q_1_1;
    assign ops[10] = op_r_1_1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Operand k of CEU_a, from its matrix coordinates.
    function automatic int exp_addr(input int k);
        int ii [9];
        int jj [9];
        ii = '{4, 7, 4, 10, 7, 10, 7, 10, 10};
        jj = '{1, 1, 4, 1, 4, 4, 7, 7, 10};
        if (k < 9) return (ii[k] - 1) * 12 + (jj[k] - 1);
        return 144 + (k - 9);
    endfunction

    // CEU behaviour at hold cycle h (h = cycles since operands became stable).
    function automatic bit ceu_v(input int h, input int stale_until, input int good_at);
        return (h >= 0) && ((h < stale_until) || (h >= good_at));
    endfunction

    // Reference outcome: first valid at or after the settle window is taken,
    // otherwise the run aborts after TMO hold cycles.
    task automatic model(input int stale_until, input int good_at, input logic [63:0] good,
                         input logic [63:0] prev, output int done_c, output bit err,
                         output logic [63:0] res);
        for (int h = 0; h < TMO; h++) begin
            if (ceu_v(h, stale_until, good_at) && h >= SETTLE) begin
                done_c = 13 + h + 1;
                err    = 1'b0;
                res    = (h < stale_until) ? STALE : good;
                return;
            end
        end
        done_c = 13 + TMO;
        err    = 1'b1;
        res    = prev;
    endtask

    // One full operation starting at the current negedge (cycle 0 = start sampled).
    task automatic run_op(input string tag, input int stale_until, input int good_at,
                          input logic [63:0] good, input int restart_at,
                          input int exp_done, input bit exp_err, input logic [63:0] exp_res);
        int rd_n = 0, ov_c = -1, done_c = -1, wr_n = 0, extra_done = 0, h;
        bit overlap = 0, err_seen = 0;
        logic [AW-1:0] wr_a = '0;
        logic [DW-1:0] wr_d = '0;
        for (int c = 0; c < TMO + 40; c++) begin
            h          = c - 13;
            start      = (c == 0) || (c == restart_at);
            ceu_valid  = ceu_v(h, stale_until, good_at);
            ceu_result = (h >= 0 && h < stale_until) ? STALE : good;
            if (rd_en) begin
                if (rd_n < 11) begin
                    chk($sformatf("%s rd_addr[%0d]", tag, rd_n), 64'(rd_addr), 64'(exp_addr(rd_n)));
                    chk($sformatf("%s rd_cycle[%0d]", tag, rd_n), 64'(c), 64'(rd_n + 1));
                end
                rd_n++;
            end
            if (rd_en && wr_en) overlap = 1'b1;
            if (ops_valid && ov_c < 0) begin
                ov_c = c;
                for (int k = 0; k < 11; k++)
                    chk($sformatf("%s op[%0d]", tag, k), ops[k], BASE + 64'(exp_addr(k)));
            end
            if (wr_en) begin
                wr_n++;
                wr_a = wr_addr;
                wr_d = wr_data;
            end
            if (done) begin
                if (done_c < 0) begin
                    done_c   = c;
                    err_seen = error;
                end else begin
                    extra_done++;
                end
            end
            if (done_c >= 0 && c == done_c + 1) begin
                chk({tag, " busy_after_done"}, 64'(busy), 64'd0);
                break;
            end
            @(posedge clk);
            @(negedge clk);
        end
        start     = 1'b0;
        ceu_valid = 1'b0;
        chk({tag, " done_cycle"}, 64'(done_c), 64'(exp_done));
        chk({tag, " error"}, 64'(err_seen), 64'(exp_err));
        chk({tag, " read_count"}, 64'(rd_n), 64'd11);
        chk({tag, " ops_valid_cycle"}, 64'(ov_c), 64'd13);
        chk({tag, " extra_done"}, 64'(extra_done), 64'd0);
        chk({tag, " rd_wr_overlap"}, 64'(overlap), 64'd0);
        chk({tag, " write_count"}, 64'(wr_n), exp_err ? 64'd0 : 64'd1);
        if (!exp_err) begin
            chk({tag, " wr_addr"}, 64'(wr_a), 64'd0);
            chk({tag, " wr_data"}, wr_d, exp_res);
        end
        chk({tag, " result_out"}, result_out, exp_res);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        logic [63:0] op_or = '0;
        for (int k = 0; k < 11; k++) op_or = op_or | ops[k];
        chk({tag, " busy"}, 64'(busy), 64'd0);
        chk({tag, " done"}, 64'(done), 64'd0);
        chk({tag, " error"}, 64'(error), 64'd0);
        chk({tag, " rd_en"}, 64'(rd_en), 64'd0);
        chk({tag, " rd_addr"}, 64'(rd_addr), 64'd0);
        chk({tag, " ops_valid"}, 64'(ops_valid), 64'd0);
        chk({tag, " wr_en"}, 64'(wr_en), 64'd0);
        chk({tag, " wr_addr"}, 64'(wr_addr), 64'd0);
        chk({tag, " wr_data"}, wr_data, 64'd0);
        chk({tag, " result_out"}, result_out, 64'd0);
        chk({tag, " op_buses"}, op_or, 64'd0);
    endtask

    typedef struct {
        int          stale_until;
        int          good_at;
        logic [63:0] good;
        int          restart_at;
        int          exp_done;
        bit          exp_err;
        logic [63:0] exp_res;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int          m_done;
        bit          m_err;
        logic [63:0] m_res;
        logic [63:0] last_res;
        bit          early_done;

        tbl[0] = '{40, 45,    64'h3FF8_0000_0000_0000, -1, 59,  1'b0, 64'h3FF8_0000_0000_0000};
        tbl[1] = '{0,  NEVER, 64'h0,                   -1, 525, 1'b1, 64'h3FF8_0000_0000_0000};
        tbl[2] = '{0,  40,    64'h4010_0000_0000_0000, 5,  54,  1'b0, 64'h4010_0000_0000_0000};
        tbl[3] = '{40, 40,    64'hC000_0000_0000_0001, 54, 54,  1'b0, 64'hC000_0000_0000_0001};
        tbl[4] = '{0,  511,   64'h1234_5678_9ABC_DEF0, -1, 525, 1'b0, 64'h1234_5678_9ABC_DEF0};
        tbl[5] = '{0,  512,   64'h5555_AAAA_5555_AAAA, -1, 525, 1'b1, 64'h1234_5678_9ABC_DEF0};

        rst        = 1'b1;
        start      = 1'b0;
        ceu_valid  = 1'b0;
        ceu_result = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++)
            run_op($sformatf("vec%0d", i), tbl[i].stale_until, tbl[i].good_at, tbl[i].good,
                   tbl[i].restart_at, tbl[i].exp_done, tbl[i].exp_err, tbl[i].exp_res);
        last_res = tbl[5].exp_res;

        // Reset during FETCH: everything clears on the following cycle.
        early_done = 1'b0;
        for (int c = 0; c <= 8; c++) begin
            start = (c == 0);
            rst   = (c == 7);
            if (done) early_done = 1'b1;
            if (c == 8) chk_all_zero("midreset");
            @(posedge clk);
            @(negedge clk);
        end
        rst   = 1'b0;
        start = 1'b0;
        chk("midreset done_seen", 64'(early_done), 64'd0);
        chk("midreset still_idle", 64'(busy), 64'd0);
        last_res = '0;
        run_op("after_reset", 40, 45, 64'h3FF8_0000_0000_0000, -1, 59, 1'b0,
               64'h3FF8_0000_0000_0000);
        last_res = 64'h3FF8_0000_0000_0000;

        for (int i = 0; i < 6; i++) begin
            int          s  = int'($urandom_range(0, SETTLE));
            int          g  = int'($urandom_range(0, TMO + 20));
            logic [63:0] gv = {$urandom, $urandom};
            model(s, g, gv, last_res, m_done, m_err, m_res);
            run_op($sformatf("rand%0d", i), s, g, gv, -1, m_done, m_err, m_res);
            last_res = m_res;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
